// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects A, B and a funct opcode from one bus, executes once,
// holds result/flags under valid/ack. Ports: i_clk, i_resetN, i_data, i_loadA/B/Op,
// i_ack, o_result, o_valid, o_opError, o_zero/o_carry/o_overflow.
// Build option: define ALU_FLAGS_EN to register zero/carry/overflow flags.
module alu_op_sequencer #(
  parameter int p_dataWidth = 8,
  parameter int p_opWidth   = 6
) (
  input  logic                   i_clk,
  input  logic                   i_resetN,
  input  logic [p_dataWidth-1:0] i_data,
  input  logic                   i_loadA,
  input  logic                   i_loadB,
  input  logic                   i_loadOp,
  input  logic                   i_ack,
  output logic [p_dataWidth-1:0] o_result,
  output logic                   o_valid,
  output logic                   o_opError,
  output logic                   o_zero,
  output logic                   o_carry,
  output logic                   o_overflow
);

  localparam int L_SW  = $clog2(p_dataWidth);
  localparam int L_MSB = p_dataWidth - 1;

  localparam logic [p_opWidth-1:0] L_ADD = p_opWidth'(6'b100000);
  localparam logic [p_opWidth-1:0] L_SUB = p_opWidth'(6'b100010);
  localparam logic [p_opWidth-1:0] L_AND = p_opWidth'(6'b100100);
  localparam logic [p_opWidth-1:0] L_OR  = p_opWidth'(6'b100101);
  localparam logic [p_opWidth-1:0] L_XOR = p_opWidth'(6'b100110);
  localparam logic [p_opWidth-1:0] L_NOR = p_opWidth'(6'b100111);
  localparam logic [p_opWidth-1:0] L_SRL = p_opWidth'(6'b000010);
  localparam logic [p_opWidth-1:0] L_SRA = p_opWidth'(6'b000011);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_EXEC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [p_dataWidth-1:0] r_a;
  logic [p_dataWidth-1:0] r_b;
  logic [p_opWidth-1:0]   r_op;
  logic [2:0]             r_mask;
  logic [p_dataWidth-1:0] r_result;
  logic                   r_opError;

  logic [p_opWidth-1:0]   w_opIn;
  logic                   w_ldA;
  logic                   w_ldB;
  logic                   w_ldOp;
  logic [L_SW-1:0]        w_sh;
  logic [p_dataWidth-1:0] w_res;
  logic                   w_err;

  generate
    if (p_dataWidth >= p_opWidth) begin : g_opSlice
      assign w_opIn = i_data[p_opWidth-1:0];
    end else begin : g_opExt
      assign w_opIn = {{(p_opWidth-p_dataWidth){1'b0}}, i_data};
    end
  endgenerate

  // One strobe per cycle wins: A over B over Op.
  assign w_ldA  = (r_state == S_COLLECT) & i_loadA;
  assign w_ldB  = (r_state == S_COLLECT) & ~i_loadA & i_loadB;
  assign w_ldOp = (r_state == S_COLLECT) & ~i_loadA & ~i_loadB & i_loadOp;

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) r_state <= S_COLLECT;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_COLLECT: if (r_mask == 3'b111) w_next = S_EXEC;
      S_EXEC:    w_next = S_DONE;
      S_DONE:    if (i_ack) w_next = S_COLLECT;
      default:   w_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_mask <= '0;
    end else begin
      if (w_ldA)  r_a  <= i_data;
      if (w_ldB)  r_b  <= i_data;
      if (w_ldOp) r_op <= w_opIn;
      if (r_state == S_DONE && i_ack) r_mask <= '0;
      else r_mask <= r_mask | {w_ldOp, w_ldB, w_ldA};
    end
  end

  assign w_sh = r_b[L_SW-1:0];

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (r_op)
      L_ADD:   w_res = r_a + r_b;
      L_SUB:   w_res = r_a - r_b;
      L_AND:   w_res = r_a & r_b;
      L_OR:    w_res = r_a | r_b;
      L_XOR:   w_res = r_a ^ r_b;
      L_NOR:   w_res = ~(r_a | r_b);
      L_SRL:   w_res = r_a >> w_sh;
      L_SRA:   w_res = $unsigned($signed(r_a) >>> w_sh);
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      r_result  <= '0;
      r_opError <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_result  <= w_res;
      r_opError <= w_err;
    end
  end

  assign o_result  = r_result;
  assign o_opError = r_opError;
  assign o_valid   = (r_state == S_DONE);

`ifdef ALU_FLAGS_EN
  logic w_isAdd;
  logic w_isSub;
  logic w_zero;
  logic w_carry;
  logic w_ovf;
  logic r_zero;
  logic r_carry;
  logic r_ovf;

  assign w_isAdd = (r_op == L_ADD);
  assign w_isSub = (r_op == L_SUB);
  assign w_zero  = ~w_err & (w_res == '0);
  // Wrapped sum below A means a carry-out; borrow is A < B unsigned.
  assign w_carry = (w_isAdd & (w_res < r_a)) |
                   (w_isSub & (r_a < r_b));
  assign w_ovf   = (w_isAdd & (r_a[L_MSB] == r_b[L_MSB]) &
                    (w_res[L_MSB] != r_a[L_MSB])) |
                   (w_isSub & (r_a[L_MSB] != r_b[L_MSB]) &
                    (w_res[L_MSB] != r_a[L_MSB]));

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_zero  <= w_zero;
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
    end
  end

  assign o_zero     = r_zero;
  assign o_carry    = r_carry;
  assign o_overflow = r_ovf;
`else
  assign o_zero     = 1'b0;
  assign o_carry    = 1'b0;
  assign o_overflow = 1'b0;
`endif

endmodule
